// File: rtl/seg_fade_pkg.sv
// Shared constants and helpers for the segment fade/PWM output stage.
// Exports SEG_COUNT, NO_SEG and fade_term(), the fade prescaler terminal count.
package seg_fade_pkg;

    localparam int SEG_COUNT = 7;
    localparam logic [2:0] NO_SEG = 3'd7;

    // Terminal count of the fade prescaler: (2^width >> 2*(3-rate)) - 1.
    // Each rate step below 3 makes the decay four times faster.
    function automatic logic [31:0] fade_term(
        input logic [1:0]  rate,
        input int unsigned width
    );
        logic [1:0]  inv;
        logic [31:0] full;
        inv  = 2'd3 - rate;
        full = 32'd1 << width;
        return (full >> {inv, 1'b0}) - 32'd1;
    endfunction

endpackage

// File: rtl/seg_fade_channel.sv
// One segment channel: brightness level with light/decay priority,
// and PWM compare producing a registered led_on bit.
// Ports: clk, reset (async active-low), i_light, i_tick, i_enable,
//        i_pwm_cnt (current PWM slot), o_led (registered lit flag).
module seg_fade_channel #(
    parameter int FADE_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_light,
    input  logic                  i_tick,
    input  logic                  i_enable,
    input  logic [FADE_WIDTH-1:0] i_pwm_cnt,
    output logic                  o_led
);

    logic [FADE_WIDTH-1:0] r_level;
    logic                  r_led;

    // A light request wins over a same-cycle decay tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_level <= '0;
        end else if (i_light) begin
            r_level <= '1;
        end else if (i_tick) begin
            r_level <= r_level >> 1;
        end
    end

    // Strict compare: level 0 is never lit, full level misses one slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_led <= 1'b0;
        end else begin
            r_led <= i_enable & (r_level > i_pwm_cnt);
        end
    end

    assign o_led = r_led;

endmodule

// File: rtl/segment_fade_pwm.sv
// Fading-trail 7-segment driver: step events light a segment at full level,
// levels decay by halving on fade ticks, and a shared PWM timebase drives pins.
// Ports: clk, reset (async active-low), step_valid, step_seg[2:0],
//        fade_rate[1:0], enable, seg_out[6:0], frame_start.
module segment_fade_pwm
    import seg_fade_pkg::*;
#(
    parameter int FADE_WIDTH         = 5,
    parameter int PWM_PRESCALE_WIDTH = 6,
    parameter int FADE_TICK_WIDTH    = 16,
    parameter int COMMON_ANODE       = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 step_valid,
    input  logic [2:0]           step_seg,
    input  logic [1:0]           fade_rate,
    input  logic                 enable,
    output logic [SEG_COUNT-1:0] seg_out,
    output logic                 frame_start
);

    logic [PWM_PRESCALE_WIDTH-1:0] r_pwm_div;
    logic [FADE_WIDTH-1:0]         r_pwm_cnt;
    logic [FADE_TICK_WIDTH-1:0]    r_fade_cnt;
    logic                          r_frame_start;

    logic                          w_div_full;
    logic                          w_wrap;
    logic [FADE_TICK_WIDTH-1:0]    w_term;
    logic                          w_fade_tick;
    logic [SEG_COUNT-1:0]          w_light;
    logic [SEG_COUNT-1:0]          w_led_on;

    assign w_div_full = &r_pwm_div;
    assign w_wrap     = w_div_full & (&r_pwm_cnt);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pwm_div     <= '0;
            r_pwm_cnt     <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_pwm_div     <= r_pwm_div + 1'b1;
            r_frame_start <= w_wrap;
            if (w_div_full) begin
                r_pwm_cnt <= r_pwm_cnt + 1'b1;
            end
        end
    end

    // Terminal count follows fade_rate live; the >= compare means a
    // switch to a faster rate past the new term ticks on the next clk.
    assign w_term = FADE_TICK_WIDTH'(
        fade_term(fade_rate, FADE_TICK_WIDTH));
    assign w_fade_tick = (r_fade_cnt >= w_term);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fade_cnt <= '0;
        end else if (w_fade_tick) begin
            r_fade_cnt <= '0;
        end else begin
            r_fade_cnt <= r_fade_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < SEG_COUNT; i++) begin : g_ch
        assign w_light[i] = step_valid
                          & (step_seg != NO_SEG)
                          & (step_seg == 3'(i));

        seg_fade_channel #(
            .FADE_WIDTH (FADE_WIDTH)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .i_light   (w_light[i]),
            .i_tick    (w_fade_tick),
            .i_enable  (enable),
            .i_pwm_cnt (r_pwm_cnt),
            .o_led     (w_led_on[i])
        );
    end

    assign seg_out     = (COMMON_ANODE != 0) ? ~w_led_on : w_led_on;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_segment_fade_pwm.sv
// Directed bench for segment_fade_pwm with fast tick/PWM parameters.
// Table-driven level sequence plus hand-written reset/enable/rate sequences.
module tb_segment_fade_pwm;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       step_valid = 1'b0;
    logic [2:0] step_seg = 3'd0;
    logic [1:0] fade_rate = 2'd3;
    logic       enable = 1'b1;
    logic [6:0] seg_out;
    logic       frame_start;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    segment_fade_pwm #(
        .FADE_WIDTH         (5),
        .PWM_PRESCALE_WIDTH (1),
        .FADE_TICK_WIDTH    (8),
        .COMMON_ANODE       (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .step_valid  (step_valid),
        .step_seg    (step_seg),
        .fade_rate   (fade_rate),
        .enable      (enable),
        .seg_out     (seg_out),
        .frame_start (frame_start)
    );

    typedef struct {
        logic       sv;
        logic [2:0] seg;
        logic [4:0] e4;
        logic [4:0] e1;
        logic [4:0] e5;
    } vec_t;

    vec_t tbl[20];

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic restart(input logic [1:0] rate);
        @(negedge clk);
        reset = 1'b0;
        step_valid = 1'b0;
        step_seg = 3'd0;
        enable = 1'b1;
        fade_rate = rate;
        @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic logic [4:0] lvl(input int i);
        case (i)
            0: return dut.g_ch[0].u_ch.r_level;
            1: return dut.g_ch[1].u_ch.r_level;
            2: return dut.g_ch[2].u_ch.r_level;
            3: return dut.g_ch[3].u_ch.r_level;
            4: return dut.g_ch[4].u_ch.r_level;
            5: return dut.g_ch[5].u_ch.r_level;
            default: return dut.g_ch[6].u_ch.r_level;
        endcase
    endfunction

    function automatic vec_t mk(input logic sv, input logic [2:0] seg,
                                input logic [4:0] e4, input logic [4:0] e1,
                                input logic [4:0] e5);
        vec_t v;
        v.sv = sv;
        v.seg = seg;
        v.e4 = e4;
        v.e1 = e1;
        v.e5 = e5;
        return v;
    endfunction

    initial begin
        int first;
        int lit;
        int others_bad;
        int off_bad;

        // rate 0: ticks at edges 4,8,12,...
        tbl[0]  = mk(1, 3'd4, 31, 0, 0);
        tbl[1]  = mk(1, 3'd1, 31, 31, 0);
        tbl[2]  = mk(0, 3'd0, 31, 31, 0);
        tbl[3]  = mk(0, 3'd0, 15, 15, 0);
        tbl[4]  = mk(0, 3'd0, 15, 15, 0);
        tbl[5]  = mk(1, 3'd7, 15, 15, 0);
        tbl[6]  = mk(0, 3'd0, 15, 15, 0);
        tbl[7]  = mk(1, 3'd5, 7, 7, 31);
        tbl[8]  = mk(0, 3'd0, 7, 7, 31);
        tbl[9]  = mk(1, 3'd7, 7, 7, 31);
        tbl[10] = mk(0, 3'd0, 7, 7, 31);
        tbl[11] = mk(0, 3'd0, 3, 3, 15);
        tbl[12] = mk(1, 3'd7, 3, 3, 15);
        tbl[13] = mk(0, 3'd0, 3, 3, 15);
        tbl[14] = mk(0, 3'd0, 3, 3, 15);
        tbl[15] = mk(0, 3'd0, 1, 1, 7);
        tbl[16] = mk(0, 3'd0, 1, 1, 7);
        tbl[17] = mk(1, 3'd7, 1, 1, 7);
        tbl[18] = mk(0, 3'd0, 1, 1, 7);
        tbl[19] = mk(0, 3'd0, 0, 0, 3);

        // async reset mid-cycle, then first frame_start
        restart(2'd3);
        step_valid = 1'b1;
        step_seg = 3'd2;
        tick();
        step_valid = 1'b0;
        tick();
        tick();
        check("lit_before_reset", seg_out, 7'h7B);
        #2;
        reset = 1'b0;
        #1;
        check("async_seg_out", seg_out, 7'h7F);
        check("async_frame", frame_start, 0);
        check("async_level", lvl(2), 0);
        check("async_pwm_cnt", dut.r_pwm_cnt, 0);
        @(negedge clk);
        reset = 1'b1;
        first = 0;
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (frame_start) begin
                first = k;
                break;
            end
        end
        check("first_frame_edge", first, 64);
        tick();
        check("frame_one_clk", frame_start, 0);

        // full-level duty over one frame
        restart(2'd3);
        step_valid = 1'b1;
        step_seg = 3'd2;
        tick();
        step_valid = 1'b0;
        check("level2_full", lvl(2), 31);
        lit = 0;
        others_bad = 0;
        for (int k = 0; k < 64; k++) begin
            tick();
            if (!seg_out[2]) lit++;
            if ((seg_out | 7'h04) != 7'h7F) others_bad++;
        end
        check("duty_lit_62", lit, 62);
        check("others_dark", others_bad, 0);

        // table: decay chain, light-vs-tick, no-op step
        restart(2'd0);
        for (int r = 0; r < 20; r++) begin
            step_valid = tbl[r].sv;
            step_seg = tbl[r].seg;
            tick();
            check($sformatf("lvl_row%0d", r),
                  {lvl(4), lvl(1), lvl(5)},
                  {tbl[r].e4, tbl[r].e1, tbl[r].e5});
        end
        step_valid = 1'b0;
        off_bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (!seg_out[4]) off_bad++;
        end
        check("seg4_stays_off", off_bad, 0);

        // enable blanking and restore
        restart(2'd3);
        step_valid = 1'b1;
        step_seg = 3'd2;
        tick();
        step_valid = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        enable = 1'b0;
        tick();
        check("blank_1clk", seg_out, 7'h7F);
        tick();
        tick();
        tick();
        check("blank_hold", seg_out, 7'h7F);
        check("blank_level_kept", lvl(2), 31);
        enable = 1'b1;
        tick();
        check("reenable_1clk", seg_out, 7'h7B);
        lit = 0;
        for (int k = 0; k < 64; k++) begin
            tick();
            if (!seg_out[2]) lit++;
        end
        check("reenable_duty", lit, 62);

        // rate change mid-count
        restart(2'd3);
        step_valid = 1'b1;
        step_seg = 3'd3;
        tick();
        step_valid = 1'b0;
        for (int k = 0; k < 99; k++) tick();
        check("fade_cnt_100", dut.r_fade_cnt, 100);
        check("no_tick_yet", lvl(3), 31);
        fade_rate = 2'd0;
        #1;
        check("tick_comb", dut.w_fade_tick, 1);
        tick();
        check("cnt_cleared", dut.r_fade_cnt, 0);
        check("lvl3_15", lvl(3), 15);
        tick();
        tick();
        tick();
        check("cnt_3", dut.r_fade_cnt, 3);
        check("lvl3_hold", lvl(3), 15);
        tick();
        check("lvl3_7", lvl(3), 7);
        for (int k = 0; k < 4; k++) tick();
        check("lvl3_3", lvl(3), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
